// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around the 6-bit ALU: launches one operation, waits SETTLE_CYCLES, then holds the result.
// Optional result flags (out_zero/out_ones) are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_a,
  input  logic [5:0] in_b,
  input  logic [3:0] in_sel,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [5:0] alu_x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_x,
  output logic [3:0] out_sel
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       out_zero,
  output logic       out_ones
`endif
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  // cnt counts the remaining settle cycles; loading N-1 makes the sample land on edge E0+N.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  assign in_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      alu_a     <= 6'd0;
      alu_b     <= 6'd0;
      alu_sel   <= 4'd0;
      out_valid <= 1'b0;
      out_x     <= 6'd0;
      out_sel   <= 4'd0;
`ifdef ALU_SEQ_FLAGS_EN
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_sel <= in_sel;
            cnt     <= CNT_INIT;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_x     <= alu_x;
            out_sel   <= alu_sel;
`ifdef ALU_SEQ_FLAGS_EN
            out_zero  <= (alu_x == 6'h00);
            out_ones  <= (alu_x == 6'h3F);
`endif
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed phases with randomized operands checked against
// a cycle-count model of the handshake timing and a behavioural ALU model (flags checked with ALU_SEQ_FLAGS_EN).
module tb_alu_op_sequencer;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_a = 6'd0;
  logic [5:0] in_b = 6'd0;
  logic [3:0] in_sel = 4'd0;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [3:0] alu_sel;
  logic [5:0] alu_x;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_x;
  logic [3:0] out_sel;
`ifdef ALU_SEQ_FLAGS_EN
  logic       out_zero;
  logic       out_ones;
`endif

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  alu_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_sel(in_sel),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_x(alu_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x(out_x),
    .out_sel(out_sel)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .out_zero(out_zero),
    .out_ones(out_ones)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the ALU function units; select F forces all-ones and select 0 forces zero.
  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b, input logic [3:0] sel);
    case (sel)
      4'h0: alu_model = 6'h00;
      4'h1: alu_model = a + b;
      4'h2: alu_model = a - b;
      4'h3: alu_model = a & b;
      4'h4: alu_model = a | b;
      4'h5: alu_model = a ^ b;
      4'h6: alu_model = ~a;
      4'h7: alu_model = {a[4:0], 1'b0};
      4'h8: alu_model = {1'b0, a[5:1]};
      4'hF: alu_model = 6'h3F;
      default: alu_model = a + b + {2'b00, sel};
    endcase
  endfunction

  always_comb alu_x = alu_model(alu_a, alu_b, alu_sel);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] a, input logic [5:0] b,
                               input logic [3:0] sel, input logic rdy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sel    = sel;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [5:0] x);
`ifdef ALU_SEQ_FLAGS_EN
    checkOutput({tag, "_zero"}, 32'(out_zero), 32'(x == 6'h00));
    checkOutput({tag, "_ones"}, 32'(out_ones), 32'(x == 6'h3F));
`else
    if (x == 6'h3F) begin
      // flags are absent in this build
    end
`endif
  endtask

  // One full operation: accept, settle (with ignored noise on the inputs), hold under backpressure, release.
  task automatic runOp(input logic [5:0] a, input logic [5:0] b, input logic [3:0] sel, input int hold_cycles);
    logic [5:0] exp_x;
    exp_x = alu_model(a, b, sel);
    applyStimulus(1'b1, a, b, sel, 1'b0);
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("launch_alu_a", 32'(alu_a), 32'(a));
    checkOutput("launch_alu_b", 32'(alu_b), 32'(b));
    checkOutput("launch_alu_sel", 32'(alu_sel), 32'(sel));
    for (int k = 1; k <= S; k++) begin
      checkOutput("settle_valid", 32'(out_valid), 32'd0);
      checkOutput("settle_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 6'($urandom), 6'($urandom), 4'($urandom), 1'b1);
      tick();
    end
    checkOutput("result_valid", 32'(out_valid), 32'd1);
    checkOutput("result_x", 32'(out_x), 32'(exp_x));
    checkOutput("result_sel", 32'(out_sel), 32'(sel));
    checkFlags("result", exp_x);
    for (int k = 0; k < hold_cycles; k++) begin
      applyStimulus(1'b1, 6'($urandom), 6'($urandom), 4'($urandom), 1'b0);
      tick();
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_x", 32'(out_x), 32'(exp_x));
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_alu_a", 32'(alu_a), 32'(a));
      checkOutput("hold_alu_sel", 32'(alu_sel), 32'(sel));
    end
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b1);
    tick();
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_ready", 32'(in_ready), 32'd1);
    checkOutput("release_alu_a", 32'(alu_a), 32'(a));
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_x"}, 32'(out_x), 32'd0);
    checkOutput({tag, "_out_sel"}, 32'(out_sel), 32'd0);
    checkOutput({tag, "_alu"}, 32'({alu_a, alu_b, alu_sel}), 32'd0);
    checkFlags(tag, 6'h15);
  endtask

  initial begin
    logic [5:0] ta;
    logic [5:0] tb;
    logic [3:0] ts;
    logic       acc;
    logic       done;
    int         last_acc;
    int         accepts;
    logic [9:0] q[$];

    $display("[TB] start, SETTLE_CYCLES=%0d", S);

    // Power-on reset
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("por_in_ready", 32'(in_ready), 32'd0);
    checkResetState("por");
    rst = 1'b0;
    #1;
    checkOutput("por_release_ready", 32'(in_ready), 32'd1);

    // All-ones result and zero result
    runOp(6'h15, 6'h2A, 4'hF, 5);
    runOp(6'h0C, 6'h33, 4'h0, 0);

    // Reset for three cycles while in HOLD
    applyStimulus(1'b1, 6'h2B, 6'h11, 4'h1, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
    for (int k = 0; k < S; k++) tick();
    checkOutput("prehold_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 6'h3A, 6'h05, 4'h2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("hold_rst_ready", 32'(in_ready), 32'd0);
      checkResetState("hold_rst");
    end
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("hold_rst_release_ready", 32'(in_ready), 32'd1);

    // Reset while the counter still has two cycles to go; that operation must vanish
    applyStimulus(1'b1, 6'h21, 6'h07, 4'h5, 1'b1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b1);
    tick();
    rst = 1'b0;
    checkResetState("settle_rst");
    for (int k = 0; k < S + 2; k++) begin
      tick();
      checkOutput("settle_rst_no_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
    runOp(6'h2E, 6'h19, 4'h4, 1);

    // Throughput with in_valid and out_ready held high
    last_acc = -1;
    accepts  = 0;
    ta = 6'($urandom);
    tb = 6'($urandom);
    ts = 4'($urandom);
    applyStimulus(1'b1, ta, tb, ts, 1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc  = in_valid & in_ready;
      done = out_valid & out_ready;
      if (done) begin
        checkOutput("tput_queue_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) checkOutput("tput_result", 32'({out_sel, out_x}), 32'(q.pop_front()));
      end
      if (acc) begin
        if (last_acc >= 0) checkOutput("tput_spacing", 32'(cyc - last_acc), 32'(S + 2));
        last_acc = cyc;
        accepts++;
        q.push_back({ts, alu_model(ta, tb, ts)});
      end
      tick();
      if (acc) begin
        ta = 6'($urandom);
        tb = 6'($urandom);
        ts = 4'($urandom);
        applyStimulus(1'b1, ta, tb, ts, 1'b1);
      end
    end
    applyStimulus(1'b0, 6'd0, 6'd0, 4'd0, 1'b0);
    checkOutput("tput_accepts", 32'(accepts), 32'd8);
    checkOutput("tput_drained", 32'(q.size()), 32'd0);

    // Random operations with random backpressure
    for (int n = 0; n < 10; n++) begin
      runOp(6'($urandom), 6'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue/capture stage wrapped around the 6-bit ALU function units. It accepts one operation (operands A, B and a 4-bit select) over a valid/ready handshake. It drives the operands stable into the ALU for a programmable settle time, then registers the ALU result and presents it downstream over a second valid/ready handshake. It sits directly upstream of the ALU operand inputs and directly downstream of the ALU result output.

## Interface
- SETTLE_CYCLES, 1, cycles between operand launch and result sample; legal range 1..15, other values are an elaboration error
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge
- in_a  in  6  operand A
- in_b  in  6  operand B
- in_sel  in  4  operation select
- alu_a  out  6  registered operand A to ALU
- alu_b  out  6  registered operand B to ALU
- alu_sel  out  4  registered select to ALU
- alu_x  in  6  ALU result, sampled once per operation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result when out_valid & out_ready at a clk edge
- out_x  out  6  registered result
- out_sel  out  4  select of the operation that produced out_x
- out_zero  out  1  out_x == 6'h00 (present only with ALU_SEQ_FLAGS_EN)
- out_ones  out  1  out_x == 6'h3F (present only with ALU_SEQ_FLAGS_EN)

## Operation
- States are IDLE, SETTLE and HOLD. A 4-bit down-counter cnt is used in SETTLE.
- in_ready = (state == IDLE) & ~rst. This is combinational.
- IDLE: on in_valid, capture in_a/in_b/in_sel into alu_a/alu_b/alu_sel, load cnt = SETTLE_CYCLES-1 and go to SETTLE. Without in_valid, stay in IDLE.
- SETTLE: if cnt != 0, decrement. If cnt == 0, load out_x <= alu_x and out_sel <= alu_sel (plus flags), set out_valid and go to HOLD.
- HOLD: out_valid = 1. out_x, out_sel and flags are held constant. On out_ready, clear out_valid and go to IDLE.
- alu_a/alu_b/alu_sel change only on acceptance. They hold their value through SETTLE, HOLD and subsequent IDLE.
- in_valid outside IDLE is ignored and nothing is captured. Upstream must hold its request until in_ready.
- alu_x is sampled exactly once per operation. Its value in other cycles has no effect.
- out_ready outside HOLD has no effect.
- Arithmetic: none on data. Widths pass through unchanged. cnt never wraps because it is only loaded with 0..14.
- Reset, in any state, on the cycle rst is high:
  - state goes to IDLE and out_valid goes to 0.
  - out_x, out_sel, alu_a, alu_b, alu_sel, cnt and flags all go to 0.
  - any in-flight operation is discarded with no output produced.
  - rst has priority over every handshake in the same cycle.

## Timing
- Reset values are all outputs 0, except in_ready, which is 1 from the first cycle after rst deasserts.
- With acceptance at edge E0, alu_* update at E0 and out_valid rises at edge E0+SETTLE_CYCLES.
- The ALU combinational path therefore has SETTLE_CYCLES full clock periods.
- With a result handshake at edge Eh, in_ready is high after Eh and the next acceptance is at Eh+1 at the earliest.
- Peak throughput with out_ready tied high is one operation every SETTLE_CYCLES+2 cycles.
- There is no pipelining and only one operation is ever in flight.

## Configuration
- ALU_SEQ_FLAGS_EN defined: out_zero and out_ones exist.
  - They are registered in the same edge as out_x, computed from alu_x at sample time.
  - They are held in HOLD and reset to 0.
- ALU_SEQ_FLAGS_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst 3 cycles mid-HOLD, then release. All outputs 0; out_valid 0; in_ready 1 the cycle after release.
- SETTLE_CYCLES=1: accept A=6'h15, B=6'h2A, sel=4'hF with the ALU model returning 6'h3F.
  - alu_a=15, alu_b=2A, alu_sel=F the cycle after acceptance.
  - out_valid rises 1 edge after acceptance with out_x=3F, out_sel=F.
  - With the macro defined: out_ones=1, out_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with new operands.
  - out_x is stable, in_ready is 0 and alu_* are unchanged.
  - After out_ready=1 for one edge: IDLE, and the new request is accepted the next edge.
- Throughput, SETTLE_CYCLES=3, out_ready=1, in_valid=1 continuously: acceptances are exactly 5 cycles apart and each out_x matches its own operands.
- Reset mid-SETTLE (SETTLE_CYCLES=4): assert rst at cnt=2. out_valid never rises for that operation and the next request is accepted normally.
- sel=4'h0 with the ALU model returning 6'h00: out_x=00, and with the macro defined out_zero=1, out_ones=0.
